// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: load opcode encodings, decoded-op
// record, lane-offset width helper and the alignment rule.
package load_unit_pkg;

  // Load opcode encodings presented by the MEM stage.
  localparam logic [7:0] EXE_LB_OP  = 8'h20;
  localparam logic [7:0] EXE_LH_OP  = 8'h21;
  localparam logic [7:0] EXE_LW_OP  = 8'h23;
  localparam logic [7:0] EXE_LBU_OP = 8'h24;
  localparam logic [7:0] EXE_LHU_OP = 8'h25;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } load_size_e;

  typedef struct packed {
    logic       known;
    logic       is_signed;
    load_size_e size;
  } load_dec_t;

  // Width of the byte-lane offset inside one memory word.
  function automatic int lane_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic load_dec_t decode_op(input logic [7:0] op);
    load_dec_t d;
    d = '{known: 1'b1, is_signed: 1'b1, size: SZ_WORD};
    case (op)
      EXE_LB_OP:  d.size = SZ_BYTE;
      EXE_LH_OP:  d.size = SZ_HALF;
      EXE_LW_OP:  d.size = SZ_WORD;
      EXE_LBU_OP: begin d.size = SZ_BYTE; d.is_signed = 1'b0; end
      EXE_LHU_OP: begin d.size = SZ_HALF; d.is_signed = 1'b0; end
      default:    d.known = 1'b0;
    endcase
    return d;
  endfunction

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input load_dec_t d, input logic [1:0] lo);
    return ((d.size == SZ_HALF) && lo[0]) || ((d.size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane extraction: picks the addressed byte/half/word out of a
// big-endian memory word and sign- or zero-extends it to DATA_W.
module load_align import load_unit_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = lane_off_w(DATA_W)
) (
  input  logic [7:0]        op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  load_dec_t          dec;
  logic [DATA_W-1:0]  shifted;
  logic signed [7:0]  b;
  logic signed [15:0] h;
  logic signed [31:0] w;

  // Shift the addressed lane to the top (lane 0 is the MSB lane), then extend.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    result  = '0;
    dec     = decode_op(op);
    shifted = data << {offset, 3'b000};
    b       = $signed(shifted[DATA_W-1 -: 8]);
    h       = $signed(shifted[DATA_W-1 -: 16]);
    w       = $signed(shifted[DATA_W-1 -: 32]);
    if (dec.known) begin
      case (dec.size)
        SZ_BYTE: result = dec.is_signed ? DATA_W'(b) : DATA_W'($unsigned(b));
        SZ_HALF: result = dec.is_signed ? DATA_W'(h) : DATA_W'($unsigned(h));
        default: result = DATA_W'(w);
      endcase
    end
  end

endmodule

// File: rtl/load_unit.sv
// Load unit between MEM stage and a variable-latency data memory.
// Tracks up to DEPTH loads in order, returns extended, tagged results.
// Optional feature: define LOAD_UNIT_ADEL_EN to detect misaligned loads and
// report them as AdEL; otherwise misaligned loads are force-aligned and issued.
module load_unit import load_unit_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_adel,
  output logic [ADDR_W-1:0] rsp_badvaddr
);

  localparam int OFF_W  = lane_off_w(DATA_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Dropped replies can pile up across repeated flushes; leave headroom.
  localparam int DROP_W = PTR_W + 4;

`ifdef LOAD_UNIT_ADEL_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]        op;
    logic [OFF_W-1:0]  offset;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic              adel;
    logic              done;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  entry_t            head_entry;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [DROP_W-1:0] drop_sum;

  load_dec_t         req_dec;
  logic              req_misaligned;
  logic              req_no_mem;
  logic [OFF_W-1:0]  req_offset;
  logic              full;
  logic              push;
  logic              pop;
  logic              head_done;

  logic              fill_hit;
  logic [PTR_W-1:0]  fill_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [CNT_W-1:0]  pending;
  logic              mem_fill;
  logic [DATA_W-1:0] align_result;

  // ---------------- request side ----------------
  assign req_dec        = decode_op(req_op);
  assign req_misaligned = ADEL_EN && req_dec.known && is_misaligned(req_dec, req_addr[1:0]);
  assign req_no_mem     = req_misaligned || !req_dec.known;
  assign full           = (count_q == CNT_W'(DEPTH));
  assign tail           = head_q + count_q[PTR_W-1:0];

  assign mem_req_valid  = req_valid && !full && !flush && !req_no_mem;
  assign mem_req_addr   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_ready      = !full && !flush && (req_no_mem || mem_req_ready);
  assign push           = req_valid && req_ready;

  // Lane offset stored with the entry; sub-size bits are ignored so an
  // unflagged misaligned load behaves as its aligned counterpart.
  always_comb begin
    req_offset = req_addr[OFF_W-1:0];
    if (req_dec.size == SZ_HALF) begin
      req_offset[0] = 1'b0;
    end else if (req_dec.size == SZ_WORD) begin
      req_offset[1:0] = 2'b00;
    end
  end

  // ---------------- reply matching ----------------
  // Find the oldest live entry still waiting for memory and count all such
  // entries (the ones whose replies must be dropped on a flush).
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head_q;
    scan_idx = head_q;
    pending  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && !fifo_q[scan_idx].done) begin
        if (!fill_hit) begin
          fill_hit = 1'b1;
          fill_idx = scan_idx;
        end
        pending = pending + CNT_W'(1);
      end
    end
  end

  assign mem_fill   = mem_rsp_valid && (drop_cnt_q == '0) && !flush && fill_hit;
  assign head_entry = fifo_q[head_q];
  assign head_done  = (count_q != '0) && head_entry.done;
  assign pop        = head_done && (!rsp_valid || rsp_ready) && !flush;

  // Drop count after a flush: existing debt plus everything still waiting,
  // less a reply that arrives in the flush cycle itself.
  always_comb begin
    drop_sum = drop_cnt_q + DROP_W'(pending);
    if (mem_rsp_valid && (drop_sum != '0)) begin
      drop_sum = drop_sum - DROP_W'(1);
    end
  end

  // ---------------- tracking FIFO ----------------
  // Entry payload: written on push, completed by matching memory replies.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; count_q alone decides which entries are live, so stale contents are never observed.
    if (push) begin
      fifo_q[tail] <= '{op:     req_op,
                        offset: req_offset,
                        tag:    req_tag,
                        addr:   req_addr,
                        adel:   req_misaligned,
                        done:   req_no_mem,
                        data:   '0};
    end
    if (mem_fill) begin
      fifo_q[fill_idx].data <= mem_rsp_data;
      fifo_q[fill_idx].done <= 1'b1;
    end
  end

  // FIFO pointers: flush empties the queue, otherwise push/pop bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || flush) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Drop counter: absorbs replies for loads squashed by a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (flush) begin
      drop_cnt_q <= drop_sum;
    end else if (mem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_q <= drop_cnt_q - DROP_W'(1);
    end
  end

  // ---------------- result path ----------------
  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .op     (head_entry.op),
    .offset (head_entry.offset),
    .data   (head_entry.data),
    .result (align_result)
  );

  // Output register: loads the completed head entry, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_tag      <= '0;
      rsp_adel     <= 1'b0;
      rsp_badvaddr <= '0;
    end else if (pop) begin
      rsp_valid    <= 1'b1;
      rsp_data     <= head_entry.adel ? '0 : align_result;
      rsp_tag      <= head_entry.tag;
      rsp_adel     <= ADEL_EN && head_entry.adel;
      rsp_badvaddr <= head_entry.addr;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule
